// File: rtl/escalonador_frame_pkg.sv
// Shared types for the frame scheduler.
// State codes, db_estado encoding and timing defaults.
package escalonador_frame_pkg;

  localparam int periodo_tick_def = 833333;
  localparam int timeout_def      = 65535;

  typedef enum logic [3:0] {
    inicial       = 4'h0,
    espera_tick   = 4'h1,
    dispara_mov   = 4'h2,
    espera_mov    = 4'h3,
    dispara_col   = 4'h4,
    espera_col    = 4'h5,
    dispara_frame = 4'h6,
    espera_frame  = 4'h7,
    dispara_envio = 4'h8,
    espera_envio  = 4'h9,
    fim_jogo      = 4'ha,
    erro          = 4'hb
  } estado_t;

  function automatic logic [3:0] db_code(
    input estado_t e
  );
    return 4'(e);
  endfunction

endpackage

// File: rtl/escalonador_frame_if.sv
// Start/done handshake bundle to sub-controllers.
// master: scheduler (drives starts); slave: sub-controllers.
interface escalonador_frame_if;

  logic movimenta;
  logic verifica_colisao;
  logic gera_frame;
  logic envia_frame;
  logic fim_movimenta;
  logic fim_colisao;
  logic fim_gera_frame;
  logic fim_envio;
  logic game_over;

  modport master (
    output movimenta,
    output verifica_colisao,
    output gera_frame,
    output envia_frame,
    input  fim_movimenta,
    input  fim_colisao,
    input  fim_gera_frame,
    input  fim_envio,
    input  game_over
  );

  modport slave (
    input  movimenta,
    input  verifica_colisao,
    input  gera_frame,
    input  envia_frame,
    output fim_movimenta,
    output fim_colisao,
    output fim_gera_frame,
    output fim_envio,
    output game_over
  );

endinterface

// File: rtl/escalonador_frame_contador_m.sv
// Modulo-M counter with clear, enable and rco.
// Ports: clock, reset, clear, enable in; rco out (at M-1 while enabled).
module contador_m #(
  parameter int M = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic rco
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] q;
  logic         fim;

  assign fim = (q == W'(M - 1));
  assign rco = enable && fim;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (enable) begin
      q <= fim ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/escalonador_frame.sv
// Game loop scheduler: one frame per tick, sequencing sub-controllers.
// Ports: clock, reset, iniciar, pausa, sub (master), status outputs.
module escalonador_frame
  import escalonador_frame_pkg::*;
#(
  parameter int PERIODO_TICK = periodo_tick_def,
  parameter int TIMEOUT      = timeout_def
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic                       pausa,
  escalonador_frame_if.master        sub,
  output logic                       ocupado,
  output logic                       overrun,
  output logic                       timeout,
  output logic [15:0]                contagem_frames,
  output logic [3:0]                 db_estado
);

  estado_t estado;
  estado_t proximo;

  logic tick;
  logic wd_fim;
  logic pending;
  logic ativo;
  logic busy;
  logic espera_sub;
  logic tick_en;
  logic arranque;

  assign ativo = !(estado inside {inicial, fim_jogo, erro});
  assign busy  = ativo && (estado != espera_tick);
  assign espera_sub = estado inside
    {espera_mov, espera_col, espera_frame, espera_envio};
  assign tick_en = ativo &&
    !((estado == espera_tick) && pausa);
  assign arranque = (estado == inicial) && iniciar;

  contador_m #(.M(PERIODO_TICK)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (estado == inicial),
    .enable (tick_en),
    .rco    (tick)
  );

  // Watchdog restarts on every entry into a sub-controller wait.
  contador_m #(.M(TIMEOUT)) u_wd (
    .clock  (clock),
    .reset  (reset),
    .clear  (!espera_sub),
    .enable (espera_sub),
    .rco    (wd_fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= inicial;
    else       estado <= proximo;
  end

  // Done inputs are tested before the watchdog so they win a tie.
  always_comb begin
    proximo = estado;
    unique case (estado)
      inicial:
        if (iniciar) proximo = espera_tick;
      espera_tick:
        if ((tick || pending) && !pausa)
          proximo = dispara_mov;
      dispara_mov:   proximo = espera_mov;
      espera_mov:
        if (sub.fim_movimenta) proximo = dispara_col;
        else if (wd_fim)       proximo = erro;
      dispara_col:   proximo = espera_col;
      espera_col:
        if (sub.fim_colisao)
          proximo = sub.game_over ? fim_jogo : dispara_frame;
        else if (wd_fim) proximo = erro;
      dispara_frame: proximo = espera_frame;
      espera_frame:
        if (sub.fim_gera_frame) proximo = dispara_envio;
        else if (wd_fim)        proximo = erro;
      dispara_envio: proximo = espera_envio;
      espera_envio:
        if (sub.fim_envio) proximo = espera_tick;
        else if (wd_fim)   proximo = erro;
      fim_jogo:
        if (!iniciar) proximo = inicial;
      erro:          proximo = erro;
      default:       proximo = inicial;
    endcase
    if (!iniciar && estado != fim_jogo && estado != erro)
      proximo = inicial;
  end

  // A tick while busy is remembered once; the 1-bit flag drops extras.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending         <= 1'b0;
      overrun         <= 1'b0;
      timeout         <= 1'b0;
      contagem_frames <= '0;
    end else if (arranque) begin
      pending         <= 1'b0;
      overrun         <= 1'b0;
      timeout         <= 1'b0;
      contagem_frames <= '0;
    end else begin
      if (estado == espera_tick && proximo == dispara_mov)
        pending <= 1'b0;
      if (tick && busy) begin
        pending <= 1'b1;
        overrun <= 1'b1;
      end
      if (espera_sub && proximo == erro)
        timeout <= 1'b1;
      if (estado == espera_envio && proximo == espera_tick)
        contagem_frames <= contagem_frames + 16'd1;
    end
  end

  always_comb begin
    sub.movimenta        = (estado == dispara_mov);
    sub.verifica_colisao = (estado == dispara_col);
    sub.gera_frame       = (estado == dispara_frame);
    sub.envia_frame      = (estado == dispara_envio);
    ocupado              = busy;
    db_estado            = db_code(estado);
  end

endmodule
